// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencing around the IF/ID register and decode
//               stage. Resolves load-use hazards and execute-stage redirects.
//               Provides a halt / single-step / resume debug FSM and
//               saturating hazard performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           rs1_addr_d_i,
    input  logic [4:0]           rs2_addr_d_i,
    input  logic [4:0]           rd_addr_e_i,
    input  logic                 reg_write_e_i,
    input  logic [1:0]           result_src_e_i,
    input  logic                 pc_src_e_i,
    input  logic                 halt_req_i,
    input  logic                 step_req_i,
    input  logic                 resume_req_i,
    output logic                 stall_f_o,
    output logic                 stall_d_o,
    output logic                 flush_d_o,
    output logic                 flush_e_o,
    output logic                 halted_o,
    output logic [CNT_WIDTH-1:0] lu_stall_cnt_o,
    output logic [CNT_WIDTH-1:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_STEP   = 2'd3
    } state_t;

    localparam logic [3:0]           C_DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE    = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_next_state;
    logic [3:0]           r_drain_cnt;
    logic [3:0]           w_drain_cnt_nxt;
    logic                 r_halted;
    logic [CNT_WIDTH-1:0] r_lu_cnt;
    logic [CNT_WIDTH-1:0] r_redir_cnt;

    logic w_lu;
    logic w_redirect;
    logic w_lu_apply;
    logic w_debug_ok;

    // Load-use hazard: a load in execute feeds a source of the decode instruction.
    assign w_lu = reg_write_e_i && (result_src_e_i == 2'b01) && (rd_addr_e_i != 5'd0) &&
                  ((rd_addr_e_i == rs1_addr_d_i) || (rd_addr_e_i == rs2_addr_d_i));
    assign w_redirect = pc_src_e_i;
    // A redirect squashes the decode instruction, so its load-use hazard is moot.
    assign w_lu_apply = w_lu && !w_redirect;
    // Debug requests are only acted on in cycles without a pipeline hazard.
    assign w_debug_ok = !w_redirect && !w_lu;

    // Zero-latency stall/flush controls: redirect > load-use > debug state.
    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        if (w_redirect) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (w_lu) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if ((r_state == S_DRAIN) || (r_state == S_HALTED)) begin
            stall_f_o = 1'b1;
            flush_d_o = 1'b1;
        end
    end

    // Debug FSM next-state and drain counter update.
    always_comb begin
        w_next_state    = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            S_RUN: begin
                if (w_debug_ok && halt_req_i) begin
                    w_next_state    = S_DRAIN;
                    w_drain_cnt_nxt = C_DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (w_redirect) begin
                    w_drain_cnt_nxt = C_DRAIN_LOAD;
                end else if (!w_lu) begin
                    if (r_drain_cnt <= 4'd1) begin
                        w_next_state    = S_HALTED;
                        w_drain_cnt_nxt = 4'd0;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt - 4'd1;
                    end
                end
            end
            S_HALTED: begin
                if (w_debug_ok) begin
                    if (resume_req_i) begin
                        w_next_state = S_RUN;
                    end else if (step_req_i) begin
                        w_next_state = S_STEP;
                    end
                end
            end
            S_STEP: begin
                w_next_state    = S_DRAIN;
                w_drain_cnt_nxt = C_DRAIN_LOAD;
            end
            default: begin
                w_next_state    = S_RUN;
                w_drain_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State, drain counter and halted flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_drain_cnt <= 4'd0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_halted    <= (w_next_state == S_HALTED);
        end
    end

    // Saturating hazard performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_cnt    <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (w_lu_apply && (r_lu_cnt != C_CNT_MAX)) begin
                r_lu_cnt <= r_lu_cnt + C_CNT_ONE;
            end
            if (w_redirect && (r_redir_cnt != C_CNT_MAX)) begin
                r_redir_cnt <= r_redir_cnt + C_CNT_ONE;
            end
        end
    end

    assign halted_o       = r_halted;
    assign lu_stall_cnt_o = r_lu_cnt;
    assign redirect_cnt_o = r_redir_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed table-driven bench for pipeline_hazard_ctrl
//               (DRAIN_CYCLES=3, CNT_WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int C_CW = 4;

    logic            clk;
    logic            rst_n;
    logic [4:0]      rs1_addr_d_i;
    logic [4:0]      rs2_addr_d_i;
    logic [4:0]      rd_addr_e_i;
    logic            reg_write_e_i;
    logic [1:0]      result_src_e_i;
    logic            pc_src_e_i;
    logic            halt_req_i;
    logic            step_req_i;
    logic            resume_req_i;
    logic            stall_f_o;
    logic            stall_d_o;
    logic            flush_d_o;
    logic            flush_e_o;
    logic            halted_o;
    logic [C_CW-1:0] lu_stall_cnt_o;
    logic [C_CW-1:0] redirect_cnt_o;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES(3),
        .CNT_WIDTH   (C_CW)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1_addr_d_i  (rs1_addr_d_i),
        .rs2_addr_d_i  (rs2_addr_d_i),
        .rd_addr_e_i   (rd_addr_e_i),
        .reg_write_e_i (reg_write_e_i),
        .result_src_e_i(result_src_e_i),
        .pc_src_e_i    (pc_src_e_i),
        .halt_req_i    (halt_req_i),
        .step_req_i    (step_req_i),
        .resume_req_i  (resume_req_i),
        .stall_f_o     (stall_f_o),
        .stall_d_o     (stall_d_o),
        .flush_d_o     (flush_d_o),
        .flush_e_o     (flush_e_o),
        .halted_o      (halted_o),
        .lu_stall_cnt_o(lu_stall_cnt_o),
        .redirect_cnt_o(redirect_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hazard kinds for the vector table.
    localparam int K_NONE = 0;   // no load in execute
    localparam int K_LU   = 1;   // load rd=5 feeding rs2=5
    localparam int K_LU0  = 2;   // same pattern but rd=0, no hazard

    typedef struct {
        int         kind;
        logic       pc;
        logic       halt;
        logic       step;
        logic       resume;
        logic [4:0] exp_out;   // {stall_f, stall_d, flush_d, flush_e, halted}
        logic [3:0] exp_lu;
        logic [3:0] exp_rc;
    } vec_t;

    vec_t vecs[29];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(input int k, input logic p, input logic h, input logic s,
                                input logic r, input logic [4:0] eo,
                                input logic [3:0] el, input logic [3:0] er);
        vec_t v;
        v.kind = k; v.pc = p; v.halt = h; v.step = s; v.resume = r;
        v.exp_out = eo; v.exp_lu = el; v.exp_rc = er;
        return v;
    endfunction

    task automatic drive(input int k, input logic p, input logic h, input logic s,
                         input logic r);
        rs1_addr_d_i   = 5'd0;
        rs2_addr_d_i   = (k == K_NONE) ? 5'd0 : ((k == K_LU) ? 5'd5 : 5'd0);
        rd_addr_e_i    = (k == K_LU) ? 5'd5 : 5'd0;
        reg_write_e_i  = (k != K_NONE);
        result_src_e_i = (k != K_NONE) ? 2'b01 : 2'b00;
        pc_src_e_i     = p;
        halt_req_i     = h;
        step_req_i     = s;
        resume_req_i   = r;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {stall_f_o, stall_d_o, flush_d_o, flush_e_o, halted_o};
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        // Cycle-by-cycle scenario; expected counters are the values seen during the cycle.
        vecs[0]  = mk(K_NONE, 0, 0, 0, 0, 5'b00000, 0, 0); // RUN idle
        vecs[1]  = mk(K_LU,   0, 0, 0, 0, 5'b11010, 0, 0); // load-use stall
        vecs[2]  = mk(K_LU0,  0, 0, 0, 0, 5'b00000, 1, 0); // rd=0: no hazard
        vecs[3]  = mk(K_LU,   1, 0, 0, 0, 5'b00110, 1, 0); // redirect beats load-use
        vecs[4]  = mk(K_NONE, 0, 1, 0, 0, 5'b00000, 1, 1); // halt request
        vecs[5]  = mk(K_NONE, 0, 0, 0, 0, 5'b10100, 1, 1); // DRAIN 3
        vecs[6]  = mk(K_NONE, 0, 1, 0, 0, 5'b10100, 1, 1); // DRAIN 2, halt ignored
        vecs[7]  = mk(K_NONE, 0, 0, 0, 0, 5'b10100, 1, 1); // DRAIN 1
        vecs[8]  = mk(K_NONE, 0, 0, 0, 0, 5'b10101, 1, 1); // HALTED
        vecs[9]  = mk(K_NONE, 0, 1, 0, 0, 5'b10101, 1, 1); // halt ignored
        vecs[10] = mk(K_NONE, 0, 0, 1, 0, 5'b10101, 1, 1); // step request
        vecs[11] = mk(K_NONE, 0, 0, 0, 0, 5'b00000, 1, 1); // STEP cycle
        vecs[12] = mk(K_NONE, 0, 0, 0, 0, 5'b10100, 1, 1); // DRAIN 3
        vecs[13] = mk(K_LU,   0, 0, 0, 0, 5'b11010, 1, 1); // lu in DRAIN, counter holds
        vecs[14] = mk(K_NONE, 0, 0, 0, 0, 5'b10100, 2, 1); // DRAIN 2
        vecs[15] = mk(K_NONE, 0, 0, 0, 0, 5'b10100, 2, 1); // DRAIN 1
        vecs[16] = mk(K_NONE, 0, 0, 0, 0, 5'b10101, 2, 1); // HALTED again
        vecs[17] = mk(K_NONE, 1, 0, 0, 0, 5'b00111, 2, 1); // redirect while halted
        vecs[18] = mk(K_NONE, 0, 0, 1, 1, 5'b10101, 2, 2); // step+resume: resume wins
        vecs[19] = mk(K_NONE, 0, 0, 0, 0, 5'b00000, 2, 2); // RUN
        vecs[20] = mk(K_NONE, 0, 1, 0, 0, 5'b00000, 2, 2); // halt request
        vecs[21] = mk(K_NONE, 0, 0, 0, 0, 5'b10100, 2, 2); // DRAIN 3
        vecs[22] = mk(K_NONE, 1, 0, 0, 0, 5'b00110, 2, 2); // redirect reloads counter
        vecs[23] = mk(K_NONE, 0, 0, 0, 0, 5'b10100, 2, 3); // DRAIN 3
        vecs[24] = mk(K_NONE, 0, 0, 0, 0, 5'b10100, 2, 3); // DRAIN 2
        vecs[25] = mk(K_NONE, 0, 0, 0, 0, 5'b10100, 2, 3); // DRAIN 1
        vecs[26] = mk(K_NONE, 0, 0, 0, 0, 5'b10101, 2, 3); // HALTED
        vecs[27] = mk(K_NONE, 0, 0, 0, 1, 5'b10101, 2, 3); // resume
        vecs[28] = mk(K_NONE, 0, 0, 0, 0, 5'b00000, 2, 3); // RUN

        drive(K_NONE, 0, 0, 0, 0);
        rst_n = 1'b0;
        #3;
        check("reset_outs", 32'(outs()), 32'b00000);
        check("reset_lu_cnt", 32'(lu_stall_cnt_o), 32'd0);
        check("reset_rc_cnt", 32'(redirect_cnt_o), 32'd0);
        #9 rst_n = 1'b1;             // released at t=12, away from the edge at 15
        @(posedge clk); #1;

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].kind, vecs[i].pc, vecs[i].halt, vecs[i].step, vecs[i].resume);
            #3;
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_lu_cnt", i), 32'(lu_stall_cnt_o), 32'(vecs[i].exp_lu));
            check($sformatf("vec%0d_rc_cnt", i), 32'(redirect_cnt_o), 32'(vecs[i].exp_rc));
            @(posedge clk); #1;
        end

        // Saturation: 20 consecutive load-use cycles from a count of 2.
        for (int i = 0; i < 20; i++) begin
            drive(K_LU, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        drive(K_NONE, 0, 0, 0, 0);
        #3;
        check("lu_cnt_saturated", 32'(lu_stall_cnt_o), 32'd15);
        check("rc_cnt_after_sat", 32'(redirect_cnt_o), 32'd3);

        // Redirect counter saturation: 14 redirects from 3 must stop at 15.
        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) begin
            drive(K_NONE, 1, 0, 0, 0);
            @(posedge clk); #1;
        end
        drive(K_NONE, 0, 0, 0, 0);
        #3;
        check("rc_cnt_saturated", 32'(redirect_cnt_o), 32'd15);

        // Asynchronous reset in the middle of DRAIN.
        @(posedge clk); #1;
        drive(K_NONE, 0, 1, 0, 0);
        @(posedge clk); #1;
        drive(K_NONE, 0, 0, 0, 0);
        @(posedge clk); #1;
        #1;
        check("mid_drain_outs", 32'(outs()), 32'b10100);
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'(outs()), 32'b00000);
        check("async_rst_lu_cnt", 32'(lu_stall_cnt_o), 32'd0);
        check("async_rst_rc_cnt", 32'(redirect_cnt_o), 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        #3;
        check("post_rst_run", 32'(outs()), 32'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequences the fetch/decode/execute pipeline around the IF/ID register and decode stage. Generates the IF/ID stall and flush controls (stall_d/flush_d), the fetch stall and the ID/EX flush. It resolves load-use hazards and control-flow redirects, and provides a halt / single-step / resume debug FSM plus saturating hazard performance counters. Sits beside the pipeline registers; all outputs drive their stall/flush inputs directly.

Parameters:
DRAIN_CYCLES, 3, cycles of bubble injection after halt/step before halted_o asserts (1..15)
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
rs1_addr_d_i  input  5  rs1 address of instruction in decode
rs2_addr_d_i  input  5  rs2 address of instruction in decode
rd_addr_e_i  input  5  rd address of instruction in execute
reg_write_e_i  input  1  execute instruction writes rd
result_src_e_i  input  2  execute result source; 2'b01 = load
pc_src_e_i  input  1  taken branch/jump redirect resolved in execute
halt_req_i  input  1  debug halt request (level, sampled in RUN)
step_req_i  input  1  single-step request (sampled in HALTED)
resume_req_i  input  1  resume request (sampled in HALTED)
stall_f_o  output  1  hold PC
stall_d_o  output  1  hold IF/ID register
flush_d_o  output  1  clear IF/ID register to bubble
flush_e_o  output  1  clear ID/EX register to bubble
halted_o  output  1  core halted, pipeline drained
lu_stall_cnt_o  output  CNT_WIDTH  load-use stall cycles
redirect_cnt_o  output  CNT_WIDTH  redirect flush events

Behaviour:
- Reset (async, rst_n=0): state RUN, drain counter 0, both perf counters 0, halted_o 0. Stall/flush outputs follow the combinational rules below from state RUN.
- lu = reg_write_e_i & (result_src_e_i==2'b01) & (rd_addr_e_i!=0) & (rd_addr_e_i==rs1_addr_d_i | rd_addr_e_i==rs2_addr_d_i).
- Stall/flush outputs are combinational from state and inputs (zero latency). State, drain counter, halted_o and counters are registered.
- Priority inside every state: redirect > load-use > debug control.
- Redirect (pc_src_e_i=1), any state: flush_d=1, flush_e=1, stall_f=0, stall_d=0. Forces stall_f=0 even in DRAIN/HALTED so the target PC loads. lu is ignored (wrong-path instruction).
- Load-use (lu=1, no redirect): stall_f=1, stall_d=1, flush_e=1, flush_d=0.
- States:
  - RUN: no hazard -> all 0. halt_req_i=1 -> DRAIN; drain counter loads DRAIN_CYCLES.
  - DRAIN: stall_f=1, flush_d=1, stall_d=0, flush_e=0. On a lu cycle the load-use rule applies instead and the counter holds; otherwise the counter decrements. Redirect reloads the counter to DRAIN_CYCLES. Counter==1 with decrement -> HALTED.
  - HALTED: stall_f=1, flush_d=1, halted_o=1 (registered, asserted the first HALTED cycle). resume_req_i -> RUN. step_req_i -> STEP. Both asserted -> resume wins. halt_req_i is ignored.
  - STEP: exactly one cycle with stall_f=0, flush_d=0 (one instruction enters IF/ID). Next state is DRAIN with the counter reloaded. If a redirect occurs in this cycle, the redirect rule applies and STEP still exits to DRAIN.
- halted_o = 0 in RUN, DRAIN and STEP. halt_req_i in STEP/DRAIN has no effect.
- lu_stall_cnt_o: +1 every cycle the load-use rule is applied. redirect_cnt_o: +1 every cycle pc_src_e_i=1. Both saturate at all-ones and never wrap.
- Reset asserted mid-DRAIN/STEP: immediate return to RUN, counters cleared.

Test Plan:
- Load-use: rd_addr_e=5, result_src_e=01, reg_write_e=1, rs2_addr_d=5 for 1 cycle in RUN -> stall_f=stall_d=flush_e=1, flush_d=0; lu_stall_cnt 0->1. Repeat with rd_addr_e=0 -> no stall.
- Redirect + load-use same cycle: pc_src_e=1 with lu conditions -> flush_d=flush_e=1, stall_f=stall_d=0; redirect_cnt=1, lu_stall_cnt unchanged.
- Halt with DRAIN_CYCLES=3: halt_req pulse in RUN -> 3 DRAIN cycles (stall_f=flush_d=1), then halted_o=1 on the 4th cycle. Inject one lu cycle during DRAIN -> halted_o delayed by exactly 1 cycle.
- Step: in HALTED pulse step_req -> one cycle stall_f=flush_d=0, halted_o=0, then 3 DRAIN cycles, halted_o=1 again. step_req and resume_req together -> RUN next cycle.
- Redirect while HALTED: pc_src_e=1 -> stall_f=0, flush_d=flush_e=1 that cycle. Redirect during DRAIN -> counter reloads, halted_o after 3 further clean cycles.
- Saturation/reset: CNT_WIDTH=4, 20 consecutive lu cycles -> lu_stall_cnt holds 15. Assert rst_n=0 mid-DRAIN -> counters 0, halted_o=0, RUN immediately (asynchronous, no clock edge needed).
